// File: rtl/display_scan_driver.sv
// Four-digit multiplexed seven-segment scanner for an ASCII clock core.
// Includes a frame snapshot, inter-slot blanking, colon blink and alarm blink.
module display_scan_driver #(
    parameter int SCAN_DIV  = 4,
    parameter int BLANK_CYC = 1,
    parameter int BLINK_DIV = 256,
    parameter bit LZ_BLANK  = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] ms_hour,
    input  logic [7:0] ls_hour,
    input  logic [7:0] ms_minute,
    input  logic [7:0] ls_minute,
    input  logic       alarm_sound,
    output logic [3:0] anode,
    output logic [6:0] seg,
    output logic       dp,
    output logic       code_err
);

    localparam int SMAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int SW   = $clog2(SMAX + 1);
    localparam int BW   = $clog2(BLINK_DIV + 1);
    localparam logic [SW-1:0] ON_LAST = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] BL_LAST = SW'(BLANK_CYC - 1);
    localparam logic [BW-1:0] BK_LAST = BW'(BLINK_DIV - 1);

    typedef enum logic {ST_BLANK = 1'b0, ST_ON = 1'b1} state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0][7:0] snap_q, snap_d;
    logic [BW-1:0]   blink_q, blink_d;
    logic            colon_q, colon_d;
    logic [BW-1:0]   acnt_q, acnt_d;
    logic            alarm_q, alarm_d;
    logic [3:0]      anode_q, anode_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic            err_q, err_d;
    logic [7:0]      code_d;
    logic            lit;

    function automatic logic [6:0] decode(input logic [7:0] c);
        case (c)
            8'h30:   decode = 7'h40;
            8'h31:   decode = 7'h79;
            8'h32:   decode = 7'h24;
            8'h33:   decode = 7'h30;
            8'h34:   decode = 7'h19;
            8'h35:   decode = 7'h12;
            8'h36:   decode = 7'h02;
            8'h37:   decode = 7'h78;
            8'h38:   decode = 7'h00;
            8'h39:   decode = 7'h10;
            8'h20:   decode = 7'h7F;
            default: decode = 7'h3F;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + SW'(1);
        idx_d   = idx_q;
        snap_d  = snap_q;
        if (state_q == ST_ON) begin
            if (cnt_q == ON_LAST) begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        end else if (cnt_q == BL_LAST) begin
            state_d = ST_ON;
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
            // A new frame begins: freeze all four codes for its duration.
            if (idx_q == 2'd3)
                snap_d = {ls_minute, ms_minute, ls_hour, ms_hour};
        end

        blink_d = (blink_q == BK_LAST) ? '0 : blink_q + BW'(1);
        colon_d = (blink_q == BK_LAST) ? ~colon_q : colon_q;

        acnt_d  = '0;
        alarm_d = 1'b0;
        if (alarm_sound) begin
            acnt_d  = (acnt_q == BK_LAST) ? '0 : acnt_q + BW'(1);
            alarm_d = (acnt_q == BK_LAST) ? ~alarm_q : alarm_q;
        end

        // Outputs are registered from next-state so they line up with it.
        lit    = (state_d == ST_ON);
        code_d = snap_d[idx_d];
        anode_d = 4'hF;
        if (lit && !alarm_d)
            anode_d = ~(4'b1000 >> idx_d);
        seg_d = 7'h7F;
        if (lit && !(LZ_BLANK && idx_d == 2'd0 && code_d == 8'h30))
            seg_d = decode(code_d);
        dp_d  = !(lit && idx_d == 2'd1 && !colon_d);
        err_d = err_q | (seg_q == 7'h3F);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            idx_q   <= 2'd3;
            snap_q  <= {4{8'h20}};
            blink_q <= '0;
            colon_q <= 1'b0;
            acnt_q  <= '0;
            alarm_q <= 1'b0;
            anode_q <= 4'hF;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            blink_q <= blink_d;
            colon_q <= colon_d;
            acnt_q  <= acnt_d;
            alarm_q <= alarm_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            err_q   <= err_d;
        end
    end

    assign anode    = anode_q;
    assign seg      = seg_q;
    assign dp       = dp_q;
    assign code_err = err_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed bench for display_scan_driver: scan order, decode, snapshot,
// error flag, reset restart, colon and alarm blink.
module tb_display_scan_driver;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] ms_hour, ls_hour, ms_minute, ls_minute;
    logic       alarm_sound;

    logic [3:0] an_a, an_b, an_c;
    logic [6:0] sg_a, sg_b, sg_c;
    logic       dp_a, dp_b, dp_c;
    logic       er_a, er_b, er_c;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] segtab [4] = '{7'h79, 7'h24, 7'h30, 7'h19};

    always #5 clock = ~clock;

    display_scan_driver dut (
        .clock(clock), .reset(reset),
        .ms_hour(ms_hour), .ls_hour(ls_hour),
        .ms_minute(ms_minute), .ls_minute(ls_minute),
        .alarm_sound(alarm_sound),
        .anode(an_a), .seg(sg_a), .dp(dp_a), .code_err(er_a)
    );

    display_scan_driver #(.LZ_BLANK(1'b0)) dut_lz0 (
        .clock(clock), .reset(reset),
        .ms_hour(ms_hour), .ls_hour(ls_hour),
        .ms_minute(ms_minute), .ls_minute(ls_minute),
        .alarm_sound(alarm_sound),
        .anode(an_b), .seg(sg_b), .dp(dp_b), .code_err(er_b)
    );

    display_scan_driver #(.BLINK_DIV(8)) dut_bk (
        .clock(clock), .reset(reset),
        .ms_hour(ms_hour), .ls_hour(ls_hour),
        .ms_minute(ms_minute), .ls_minute(ls_minute),
        .alarm_sound(alarm_sound),
        .anode(an_c), .seg(sg_c), .dp(dp_c), .code_err(er_c)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected anode j clocks into a scan that starts at index 0.
    function automatic logic [3:0] scan_an(input int j);
        logic [3:0] one;
        int slot, pos;
        one  = 4'b1000;
        slot = (j / 5) % 4;
        pos  = j % 5;
        return (pos < 4) ? ~(one >> slot) : 4'hF;
    endfunction

    function automatic logic scan_dp(input int j, input logic colon);
        int slot, pos;
        slot = (j / 5) % 4;
        pos  = j % 5;
        return !((slot == 1) && (pos < 4) && !colon);
    endfunction

    initial begin
        reset       = 1'b1;
        alarm_sound = 1'b0;
        ms_hour     = 8'h31;
        ls_hour     = 8'h32;
        ms_minute   = 8'h33;
        ls_minute   = 8'h34;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_anode", an_a, 4'hF);
        chk("rst_seg", sg_a, 7'h7F);
        chk("rst_dp", dp_a, 1'b1);
        chk("rst_err", er_a, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk($sformatf("f0_an%0d", i), an_a, scan_an(i));
            chk($sformatf("f0_sg%0d", i), sg_a,
                (i % 5 < 4) ? segtab[i / 5] : 7'h7F);
            chk($sformatf("f0_dp%0d", i), dp_a, scan_dp(i, 1'b0));
        end
        ms_hour = 8'h30;

        for (int i = 20; i <= 72; i++) begin
            @(negedge clock);
            case (i)
                20: begin
                    chk("lz_an", an_a, 4'b0111);
                    chk("lz_sg", sg_a, 7'h7F);
                    chk("lz0_an", an_b, 4'b0111);
                    chk("lz0_sg", sg_b, 7'h40);
                end
                24: chk("dp_blank", dp_a, 1'b1);
                25: chk("dp_colon", dp_a, 1'b0);
                26: ls_minute = 8'h39;
                35: begin
                    chk("snap_an", an_a, 4'b1110);
                    chk("snap_sg", sg_a, 7'h19);
                end
                39: ms_minute = 8'h41;
                50: begin
                    chk("dash_an", an_a, 4'b1101);
                    chk("dash_sg", sg_a, 7'h3F);
                    chk("err_pre", er_a, 1'b0);
                end
                51: begin
                    chk("err_set", er_a, 1'b1);
                    ms_minute = 8'h33;
                end
                55: chk("new_sg", sg_a, 7'h10);
                70: begin
                    chk("ok_sg", sg_a, 7'h30);
                    chk("err_stk", er_a, 1'b1);
                end
                72: chk("mid_an", an_a, 4'b1101);
                default: ;
            endcase
        end
        reset = 1'b1;
        @(negedge clock);
        chk("mr_anode", an_a, 4'hF);
        chk("mr_seg", sg_a, 7'h7F);
        chk("mr_dp", dp_a, 1'b1);
        chk("mr_err", er_a, 1'b0);
        reset = 1'b0;

        @(negedge clock);
        chk("rs_an", an_a, 4'b0111);
        chk("rs_lz0", sg_b, 7'h40);
        chk("bk_an0", an_c, scan_an(0));
        alarm_sound = 1'b1;

        for (int k = 1; k <= 30; k++) begin
            logic forced;
            logic colon;
            @(negedge clock);
            forced = ((k >= 8) && (k <= 15)) || (k == 24);
            colon  = ((k + 1) / 8) % 2 == 1;
            chk($sformatf("al_an%0d", k), an_c,
                forced ? 4'hF : scan_an(k));
            chk($sformatf("al_dp%0d", k), dp_c, scan_dp(k, colon));
            if (k == 24)
                alarm_sound = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/display_scan_driver.md
DISPLAY_SCAN_DRIVER -- requirements
Module: display_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4: clocks each digit is lit per scan slot (>=1).
REQ-002 SHALL have parameter BLANK_CYC, default 1: all-off clocks between slots for ghosting suppression (>=1).
REQ-003 SHALL have parameter BLINK_DIV, default 256: clocks per half-period of the colon and alarm blink (>=1).
REQ-004 SHALL have parameter LZ_BLANK, default 1: 1 blanks a leading ASCII '0' in the hour tens digit.
REQ-005 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 ms_hour, ls_hour, ms_minute, ls_minute  input  8 each  ASCII digit codes from the clock core.
REQ-008 alarm_sound  input  1  alarm active; requests display blink.
REQ-009 anode  output  4  active-low digit enables: [3]=ms_hour, [2]=ls_hour, [1]=ms_minute, [0]=ls_minute.
REQ-010 seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-011 dp  output  1  active-low colon / decimal point.
REQ-012 code_err  output  1  sticky flag: an invalid code was displayed.

Function
REQ-013 Scan FSM SHALL have states ON and BLANK: ON lasts exactly SCAN_DIV clocks, BLANK exactly BLANK_CYC clocks.
REQ-014 Digit index SHALL advance 0->1->2->3->0 on each BLANK->ON transition; index 0 = ms_hour.
REQ-015 On every BLANK->ON transition into index 0, all four codes SHALL be latched into a frame snapshot; the display SHALL use only the snapshot, so input changes appear at the next frame, never mid-frame.
REQ-016 Decode SHALL map 0x30..0x39 to '0'..'9' = 40,79,24,30,19,12,02,78,00,10 (hex), 0x20 to 7F (blank), and any other code to 3F (dash).
REQ-017 A displayed dash SHALL set code_err on the next clock; code_err SHALL clear only on reset.
REQ-018 With LZ_BLANK=1 and snapshot ms_hour=0x30, the index-0 slot SHALL drive seg=7F with its anode still enabled.
REQ-019 In ON, anode SHALL enable only the indexed digit; in BLANK, anode=1111 and seg=7F.
REQ-020 A free-running blink counter SHALL toggle colon_phase every BLINK_DIV clocks; dp SHALL be 0 only in the ON slot of index 1 while colon_phase=0, else 1.
REQ-021 While alarm_sound=1, a separate counter SHALL toggle alarm_phase every BLINK_DIV clocks; alarm_phase=1 SHALL force anode=1111 while the scan FSM keeps running.
REQ-022 alarm_sound=0 SHALL clear the alarm counter and alarm_phase at the next clock, restoring anodes within one clock.
REQ-023 anode, seg and dp SHALL be functions of registered state only; no combinational path from the code inputs to the outputs.

Reset
REQ-024 Reset SHALL force state=BLANK, index=3, all counters and both phases to 0, snapshot to 0x20 each, code_err=0.
REQ-025 During reset and in the clock after it, outputs SHALL be anode=1111, seg=7F, dp=1.
REQ-026 After reset deasserts, the first ON slot SHALL be index 0 with a fresh snapshot, BLANK_CYC clocks later.
REQ-027 Reset asserted mid-frame or mid-blink SHALL take effect at that edge and discard the snapshot.

Verification
REQ-028 Defaults, codes "1","2","3","4": after reset, anode repeats 0111x4,1111x1,1011x4,1111x1,1101x4,1111x1,1110x4,1111x1; seg in ON slots 79,24,30,19.
REQ-029 ms_hour=0x30, LZ_BLANK=1: index-0 slot anode=0111, seg=7F; with LZ_BLANK=0, seg=40.
REQ-030 ls_minute changes "4"->"9" during index 1: index-3 slot of the current frame still shows 19; the next frame shows 10.
REQ-031 ms_minute=0x41: index-2 slot seg=3F, code_err=1 next clock; it stays 1 after the code returns to 0x33 until reset.
REQ-032 BLINK_DIV=8, alarm_sound=1: anode forced 1111 for 8 clocks and scanning for 8, alternately; alarm_sound=0 restores scanning next clock; dp low in index-1 slots only when colon_phase=0.
REQ-033 Reset pulsed during index 2 ON: next clock anode=1111, seg=7F, code_err=0; scan restarts at index 0 after BLANK_CYC clocks.
